// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
//   Packs variable-length, right-aligned Huffman codewords MSB-first into
//   fixed DATA_W-bit words. A flush pulse drains the remaining bits as a
//   final, zero-padded word marked with word_last (nbits may be 0).
//
// Ports
//   ACLK, ARESET        clock (rising edge), asynchronous active-high reset
//   clr                 synchronous soft clear, same effect as ARESET
//   code_valid/ready    codeword handshake; code_bits/code_len carry the code
//   flush               one-cycle pulse: emit remaining bits + end marker
//   word_valid/ready    packed word handshake
//   word_data           packed bits, left-aligned, zero-padded
//   word_nbits          valid bits in word_data
//   word_last           final word of a flushed stream
//   busy                bits held, word pending, or flush in progress
//   len_err             sticky: a code longer than MAX_CODE_LEN was offered
//   bit_count           total valid code bits accepted (wraps)
module huffman_bit_packer #(
    parameter int DATA_W       = 32,
    parameter int MAX_CODE_LEN = 16,
    parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1),
    parameter int NB_W         = $clog2(DATA_W + 1)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    clr,
    input  logic                    code_valid,
    output logic                    code_ready,
    input  logic [MAX_CODE_LEN-1:0] code_bits,
    input  logic [LEN_W-1:0]        code_len,
    input  logic                    flush,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [DATA_W-1:0]       word_data,
    output logic [NB_W-1:0]         word_nbits,
    output logic                    word_last,
    output logic                    busy,
    output logic                    len_err,
    output logic [31:0]             bit_count
);

    localparam int ACC_W  = DATA_W + MAX_CODE_LEN;
    localparam int FILL_W = $clog2(ACC_W + 1);

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                code_ready_q, code_ready_d;
    logic                word_valid_q, word_valid_d;
    logic [DATA_W-1:0]   word_data_q, word_data_d;
    logic [NB_W-1:0]     word_nbits_q, word_nbits_d;
    logic                word_last_q, word_last_d;
    logic                len_err_q, len_err_d;
    logic [31:0]         bit_count_q, bit_count_d;

    logic                    accept;
    logic                    out_free;
    logic [MAX_CODE_LEN-1:0] code_masked;
    logic [ACC_W-1:0]        code_ext;
    logic [FILL_W-1:0]       ins_shift;

    // Bits above code_len are don't-care on the input, so they are cleared
    // before the code is ORed into the accumulator.
    assign code_masked = code_bits & ~({MAX_CODE_LEN{1'b1}} << code_len);
    assign code_ext    = {{DATA_W{1'b0}}, code_masked};
    // Position the code directly below the bits already held (never 0,
    // since fill<DATA_W and code_len<=MAX_CODE_LEN whenever a code lands).
    assign ins_shift   = FILL_W'(ACC_W) - fill_q - FILL_W'(code_len);

    assign accept   = code_valid && code_ready_q;
    assign out_free = !word_valid_q || word_ready;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_nbits_d = word_nbits_q;
        word_last_d  = word_last_q;
        len_err_d    = len_err_q;
        bit_count_d  = bit_count_q;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (fill_q >= FILL_W'(DATA_W) && out_free) begin
            // Full word: hand over the top bits and slide the rest up.
            word_valid_d = 1'b1;
            word_data_d  = acc_q[ACC_W-1 -: DATA_W];
            word_nbits_d = NB_W'(DATA_W);
            word_last_d  = 1'b0;
            acc_d        = acc_q << DATA_W;
            fill_d       = fill_q - FILL_W'(DATA_W);
        end else if (state_q == ST_FLUSH && out_free) begin
            // Final partial word; bits below fill are always zero already.
            word_valid_d = 1'b1;
            word_data_d  = acc_q[ACC_W-1 -: DATA_W];
            word_nbits_d = NB_W'(fill_q);
            word_last_d  = 1'b1;
            acc_d        = '0;
            fill_d       = '0;
            state_d      = ST_PACK;
        end

        // Acceptance needs PACK and fill<DATA_W, so it never coincides with
        // either word load above.
        if (accept) begin
            if (code_len > LEN_W'(MAX_CODE_LEN)) begin
                len_err_d = 1'b1;
            end else if (code_len != '0) begin
                acc_d       = acc_q | (code_ext << ins_shift);
                fill_d      = fill_q + FILL_W'(code_len);
                bit_count_d = bit_count_q + 32'(code_len);
            end
        end

        if (state_q == ST_PACK && flush) begin
            state_d = ST_FLUSH;
        end

        code_ready_d = (state_d == ST_PACK) && (fill_d < FILL_W'(DATA_W));

        if (clr) begin
            state_d      = ST_PACK;
            acc_d        = '0;
            fill_d       = '0;
            code_ready_d = 1'b0;
            word_valid_d = 1'b0;
            word_data_d  = '0;
            word_nbits_d = '0;
            word_last_d  = 1'b0;
            len_err_d    = 1'b0;
            bit_count_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_PACK;
            acc_q        <= '0;
            fill_q       <= '0;
            code_ready_q <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_nbits_q <= '0;
            word_last_q  <= 1'b0;
            len_err_q    <= 1'b0;
            bit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            code_ready_q <= code_ready_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_nbits_q <= word_nbits_d;
            word_last_q  <= word_last_d;
            len_err_q    <= len_err_d;
            bit_count_q  <= bit_count_d;
        end
    end

    assign code_ready = code_ready_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_nbits = word_nbits_q;
    assign word_last  = word_last_q;
    assign len_err    = len_err_q;
    assign bit_count  = bit_count_q;
    assign busy       = (fill_q != '0) || word_valid_q || (state_q == ST_FLUSH);

endmodule
